// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes and
// data-memory wait stalls with a timeout trap, plus saturating statistics.
module pipeline_stall_ctrl #(
  parameter int TIMEOUT = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ID_RS1_i,
  input  logic [4:0]  ID_RS2_i,
  input  logic [4:0]  ID_EX_Rd_i,
  input  logic        ID_EX_MemRead_i,
  input  logic        Branch_taken_i,
  input  logic        EX_MEM_MemReq_i,
  input  logic        dmem_ack_i,
  input  logic        clr_cnt_i,
  output logic        PC_Write_o,
  output logic        IF_ID_Write_o,
  output logic        NoOp_o,
  output logic        IF_ID_Flush_o,
  output logic        Pipe_Stall_o,
  output logic        timeout_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LIM = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, ERROR} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          hazard, memstall;
  logic          pc_wr, ifid_wr, noop, flush;

  assign hazard = ID_EX_MemRead_i && (ID_EX_Rd_i != 5'd0) &&
                  ((ID_EX_Rd_i == ID_RS1_i) || (ID_EX_Rd_i == ID_RS2_i));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    memstall     = 1'b0;
    case (state)
      IDLE: begin
        // An ack in the request cycle is a zero-wait access.
        if (EX_MEM_MemReq_i && !dmem_ack_i) begin
          memstall     = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_nxt = IDLE;
        end else begin
          memstall = 1'b1;
          if (wait_cnt == WAIT_LIM) state_nxt = ERROR;
          else                      wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      ERROR:   memstall = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pc_wr   = 1'b1;
    ifid_wr = 1'b1;
    noop    = 1'b0;
    flush   = 1'b0;
    if (memstall) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
    end else if (hazard) begin
      // A taken branch here is dropped; it re-resolves once the bubble clears.
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
      noop    = 1'b1;
    end else if (Branch_taken_i) begin
      flush   = 1'b1;
    end
  end

  // Reset forces every control output low regardless of the clock.
  assign PC_Write_o    = rst_i & pc_wr;
  assign IF_ID_Write_o = rst_i & ifid_wr;
  assign NoOp_o        = rst_i & noop;
  assign IF_ID_Flush_o = rst_i & flush;
  assign Pipe_Stall_o  = rst_i & memstall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      if ((state == MEM_WAIT) && (state_nxt == ERROR)) timeout_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (clr_cnt_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if ((Pipe_Stall_o || NoOp_o) && (stall_cnt_o != 16'hFFFF))
        stall_cnt_o <= stall_cnt_o + 16'd1;
      if (IF_ID_Flush_o && (flush_cnt_o != 16'hFFFF))
        flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end

endmodule
